// File: rtl/gpio_pkg.sv
// Shared constants for the memory-mapped GPIO bank: window geometry,
// per-channel register offsets and edge-detect mode encodings.
package gpio_pkg;

    // 128-byte window, 32 bytes per channel, word registers
    localparam int unsigned WINDOW_BITS      = 7;
    localparam int unsigned CHAN_STRIDE_BITS = 5;
    localparam int unsigned OFS_BITS         = 3;

    localparam logic [OFS_BITS-1:0] GPIO_OFS_OUT    = 3'd0;
    localparam logic [OFS_BITS-1:0] GPIO_OFS_IN     = 3'd1;
    localparam logic [OFS_BITS-1:0] GPIO_OFS_STATUS = 3'd2;
    localparam logic [OFS_BITS-1:0] GPIO_OFS_IRQ_EN = 3'd3;
    localparam logic [OFS_BITS-1:0] GPIO_OFS_MODE   = 3'd4;

    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_OFF  = 2'b11
    } gpio_mode_e;

endpackage

// File: rtl/gpio_mmio_bank_if.sv
// Word-access memory bus between the datapath and the GPIO bank.
//   addr  : byte address (IorD mux)
//   wdata : write data (B register)
//   we    : write strobe (MemWrite)
//   rdata : combinational read data
//   hit   : address falls inside the bank window
interface gpio_mmio_bank_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic             we;
    logic [WIDTH-1:0] rdata;
    logic             hit;

    modport master (output addr, output wdata, output we, input rdata, input hit);
    modport slave  (input addr, input wdata, input we, output rdata, output hit);
endinterface

// File: rtl/gpio_channel.sv
// One GPIO port: output register, two-flop input synchroniser, per-bit edge
// detection, W1C status, interrupt enable and mode registers.
//   clk, reset  : clock, asynchronous active-high reset
//   we          : write strobe already qualified for this channel
//   ofs         : register offset within the channel
//   wdata       : register write data (stored width)
//   mode_wdata  : low two write-data bits for the MODE register
//   prime_done  : edge detection enabled once the synchroniser has filled
//   pins        : asynchronous input pins
//   pins_o      : registered output pins
//   rdata_c     : read word for the addressed register
//   irq_c       : any enabled status bit set
module gpio_channel
    import gpio_pkg::*;
#(
    parameter int unsigned GPIO_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [OFS_BITS-1:0]   ofs,
    input  logic [GPIO_WIDTH-1:0] wdata,
    input  logic [1:0]            mode_wdata,
    input  logic                  prime_done,
    input  logic [GPIO_WIDTH-1:0] pins,
    output logic [GPIO_WIDTH-1:0] pins_o,
    output logic [GPIO_WIDTH-1:0] rdata_c,
    output logic                  irq_c
);

    logic [GPIO_WIDTH-1:0] out_q;
    logic [GPIO_WIDTH-1:0] status_q;
    logic [GPIO_WIDTH-1:0] irq_en_q;
    gpio_mode_e            mode_q;
    logic [GPIO_WIDTH-1:0] s1_q;
    logic [GPIO_WIDTH-1:0] s2_q;
    logic [GPIO_WIDTH-1:0] prev_q;

    logic [GPIO_WIDTH-1:0] rise;
    logic [GPIO_WIDTH-1:0] fall;
    logic [GPIO_WIDTH-1:0] edge_hit;
    logic [GPIO_WIDTH-1:0] w1c_mask;
    logic [GPIO_WIDTH-1:0] status_nxt;

    // Edge selection and status update; a new edge wins over a same-cycle clear
    always_comb begin
        rise     = s2_q & ~prev_q;
        fall     = ~s2_q & prev_q;
        edge_hit = '0;
        case (mode_q)
            MODE_RISE: edge_hit = rise;
            MODE_FALL: edge_hit = fall;
            MODE_BOTH: edge_hit = rise | fall;
            default:   edge_hit = '0;
        endcase
        if (!prime_done) begin
            edge_hit = '0;
        end
        w1c_mask = '0;
        if (we && (ofs == GPIO_OFS_STATUS)) begin
            w1c_mask = wdata;
        end
        status_nxt = (status_q & ~w1c_mask) | edge_hit;
    end

    // Register state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q    <= '0;
            status_q <= '0;
            irq_en_q <= '0;
            mode_q   <= MODE_RISE;
            s1_q     <= '0;
            s2_q     <= '0;
            prev_q   <= '0;
        end else begin
            s1_q     <= pins;
            s2_q     <= s1_q;
            prev_q   <= s2_q;
            status_q <= status_nxt;
            if (we) begin
                case (ofs)
                    GPIO_OFS_OUT:    out_q    <= wdata;
                    GPIO_OFS_IRQ_EN: irq_en_q <= wdata;
                    GPIO_OFS_MODE:   mode_q   <= gpio_mode_e'(mode_wdata);
                    default: ;
                endcase
            end
        end
    end

    // Register read mux
    always_comb begin
        rdata_c = '0;
        case (ofs)
            GPIO_OFS_OUT:    rdata_c = out_q;
            GPIO_OFS_IN:     rdata_c = s2_q;
            GPIO_OFS_STATUS: rdata_c = status_q;
            GPIO_OFS_IRQ_EN: rdata_c = irq_en_q;
            GPIO_OFS_MODE:   rdata_c = GPIO_WIDTH'(mode_q);
            default:         rdata_c = '0;
        endcase
    end

    assign pins_o = out_q;
    assign irq_c  = |(status_q & irq_en_q);

endmodule

// File: rtl/gpio_mmio_bank.sv
// Memory-mapped multi-channel GPIO bank sitting beside the memory system.
// Decodes its own 128-byte window, fans writes out to the channels and
// muxes their read words back; irq is the OR of the channel interrupts.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : word-access memory bus (slave side)
//   gpio_i     : asynchronous pins, channel c at [c*GPIO_WIDTH +: GPIO_WIDTH]
//   gpio_o     : registered output pins, same packing
//   irq        : combined interrupt
module gpio_mmio_bank
    import gpio_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      GPIO_WIDTH = 16,
    parameter int unsigned      CHANNELS   = 2,
    parameter logic [WIDTH-1:0] BASE_ADDR  = 32'h0000_0400
) (
    input  logic                           clk,
    input  logic                           reset,
    gpio_mmio_bank_if.slave                bus,
    input  logic [CHANNELS*GPIO_WIDTH-1:0] gpio_i,
    output logic [CHANNELS*GPIO_WIDTH-1:0] gpio_o,
    output logic                           irq
);

    localparam int unsigned CSEL_BITS = WINDOW_BITS - CHAN_STRIDE_BITS;

    logic                  hit;
    logic [CSEL_BITS-1:0]  chan_sel;
    logic [OFS_BITS-1:0]   ofs;
    logic [1:0]            prime_q;
    logic                  prime_done;
    logic [GPIO_WIDTH-1:0] rd_words [CHANNELS];
    logic [CHANNELS-1:0]   irq_bits;
    logic [GPIO_WIDTH-1:0] rd_sel;
    logic                  unused_bits;

    // Address decode
    assign hit      = (bus.addr[WIDTH-1:WINDOW_BITS] == BASE_ADDR[WIDTH-1:WINDOW_BITS]);
    assign chan_sel = bus.addr[WINDOW_BITS-1:CHAN_STRIDE_BITS];
    assign ofs      = bus.addr[CHAN_STRIDE_BITS-1:2];

    // Byte offset and high write-data bits carry no information for the bank
    assign unused_bits = ^{bus.addr[1:0], bus.wdata};

    // Startup guard: holds off edge detection until the synchroniser and
    // prev stage have been loaded from real pin samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prime_q <= 2'd0;
        end else if (prime_q != 2'd3) begin
            prime_q <= prime_q + 2'd1;
        end
    end
    assign prime_done = (prime_q == 2'd3);

    // Channels; unpopulated channel slots decode to holes
    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic chan_we;
        assign chan_we = bus.we & hit & (chan_sel == CSEL_BITS'(g));

        gpio_channel #(
            .GPIO_WIDTH (GPIO_WIDTH)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .we         (chan_we),
            .ofs        (ofs),
            .wdata      (bus.wdata[GPIO_WIDTH-1:0]),
            .mode_wdata (bus.wdata[1:0]),
            .prime_done (prime_done),
            .pins       (gpio_i[g*GPIO_WIDTH +: GPIO_WIDTH]),
            .pins_o     (gpio_o[g*GPIO_WIDTH +: GPIO_WIDTH]),
            .rdata_c    (rd_words[g]),
            .irq_c      (irq_bits[g])
        );
    end

    // Read mux across channels
    always_comb begin
        rd_sel = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (chan_sel == CSEL_BITS'(i)) begin
                rd_sel = rd_words[i];
            end
        end
    end

    assign bus.rdata = hit ? WIDTH'(rd_sel) : '0;
    assign bus.hit   = hit;
    assign irq       = |irq_bits;

endmodule
